// File: rtl/e203_rst_sequencer_pkg.sv
// Shared definitions for the SoC reset sequencer: state encodings, default
// timing parameters and the width helper for the shared phase counter.
// The state encodings are also decoded by the SoC status CSR, so they must
// not be renumbered.
package e203_rst_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABLE    = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RUN       = 3'd3,
    ST_LOST      = 3'd4
  } seq_state_e;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_LOCK_STABLE_CYC = 1024;
  localparam int DEF_RST_HOLD_CYC    = 256;
  localparam int DEF_DBNC_CYC        = 16;
  localparam int DEF_LOSS_CNT_W      = 8;

  // Width of a counter that must hold 0 .. max(a,b)-1; never below 1 bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/e203_rst_sequencer_if.sv
// Status/control bundle between the reset sequencer and the SoC side.
//   pll_lock, wakeup_raw   asynchronous pad/PLL levels into the sequencer
//   sw_rst_req             one-cycle synchronous request to re-run HOLD
//   soc_erst_n, rst_done   registered reset release / done indication
//   dwakeup_n              debounced wakeup, active-low
//   seq_state              current FSM state encoding
//   lock_loss_cnt          saturating count of RUN->LOST transitions
// The sequencer uses the slave modport; the SoC/environment uses master.
interface e203_rst_sequencer_if #(
  parameter int LOSS_CNT_W = 8
);
  logic                  pll_lock;
  logic                  wakeup_raw;
  logic                  sw_rst_req;
  logic                  soc_erst_n;
  logic                  dwakeup_n;
  logic                  rst_done;
  logic [2:0]            seq_state;
  logic [LOSS_CNT_W-1:0] lock_loss_cnt;

  modport slave (
    input  pll_lock, wakeup_raw, sw_rst_req,
    output soc_erst_n, dwakeup_n, rst_done, seq_state, lock_loss_cnt
  );

  modport master (
    output pll_lock, wakeup_raw, sw_rst_req,
    input  soc_erst_n, dwakeup_n, rst_done, seq_state, lock_loss_cnt
  );
endinterface

// File: rtl/e203_rst_sequencer_sync_debounce.sv
// Multi-flop synchroniser followed by an optional level filter.
//   clk, rst    system clock, async active-high reset
//   async_i     asynchronous input level
//   level_o     filtered level (active-high, resets to 0)
// With DBNC_CYC > 1 the output only follows the synchronised input after it
// has differed from the current output for DBNC_CYC consecutive cycles.
// With DBNC_CYC == 1 the filter is bypassed and level_o is the last sync flop.
module e203_rst_sequencer_sync_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DBNC_CYC    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_s;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  if (DBNC_CYC > 1) begin : g_dbnc
    localparam int DW = $clog2(DBNC_CYC);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DBNC_CYC - 1);

    logic          filt_q, filt_d;
    logic [DW-1:0] dcnt_q, dcnt_d;

    // Any sample agreeing with the current output restarts the run length.
    always_comb begin
      filt_d = filt_q;
      dcnt_d = '0;
      if (sync_s != filt_q) begin
        if (dcnt_q == DCNT_LAST) filt_d = sync_s;
        else                     dcnt_d = dcnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        filt_q <= 1'b0;
        dcnt_q <= '0;
      end else begin
        filt_q <= filt_d;
        dcnt_q <= dcnt_d;
      end
    end

    assign level_o = filt_q;
  end else begin : g_bypass
    assign level_o = sync_s;
  end

endmodule

// File: rtl/e203_rst_sequencer.sv
// SoC reset sequencer. Holds the SoC in reset until pll_lock has been stable
// for LOCK_STABLE_CYC cycles, keeps it there RST_HOLD_CYC more cycles, then
// releases it. Re-asserts reset on lock loss or on a software request, and
// produces a debounced active-low wakeup from the raw wakeup pad.
//   hfextclk   PLL high-frequency clock
//   globalrst  async reset, active-high
//   bus        slave side of e203_rst_sequencer_if (see interface header)
//
// state      | meaning
// WAIT_LOCK  | waiting for synchronised pll_lock, counter cleared
// STABLE     | counting consecutive locked cycles
// HOLD       | lock proven, keeping SoC in reset for the hold time
// RUN        | SoC out of reset
// LOST       | one-cycle marker after lock loss, then WAIT_LOCK
module e203_rst_sequencer
  import e203_rst_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
  parameter int RST_HOLD_CYC    = DEF_RST_HOLD_CYC,
  parameter int DBNC_CYC        = DEF_DBNC_CYC,
  parameter int LOSS_CNT_W      = DEF_LOSS_CNT_W
) (
  input  logic                       hfextclk,
  input  logic                       globalrst,
  e203_rst_sequencer_if.slave        bus
);

  localparam int CNT_W = cnt_width(LOCK_STABLE_CYC, RST_HOLD_CYC);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYC - 1);

  logic lock_s;
  logic wake_lvl;

  e203_rst_sequencer_sync_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DBNC_CYC    (1)
  ) u_lock_sync (
    .clk     (hfextclk),
    .rst     (globalrst),
    .async_i (bus.pll_lock),
    .level_o (lock_s)
  );

  e203_rst_sequencer_sync_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DBNC_CYC    (DBNC_CYC)
  ) u_wake_dbnc (
    .clk     (hfextclk),
    .rst     (globalrst),
    .async_i (bus.wakeup_raw),
    .level_o (wake_lvl)
  );

  seq_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  run_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) state_d = ST_STABLE;
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        // Lock loss takes priority over a coincident software request.
        if (!lock_s) begin
          state_d = ST_LOST;
          if (loss_q != '1) loss_d = loss_q + 1'b1;
        end else if (bus.sw_rst_req) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_LOST: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // run_q is loaded from the next state so reset release/re-assert lands on
  // the same edge the state enters/leaves RUN, straight from a flop.
  always_ff @(posedge hfextclk or posedge globalrst) begin
    if (globalrst) begin
      state_q <= ST_WAIT_LOCK;
      cnt_q   <= '0;
      loss_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      loss_q  <= loss_d;
      run_q   <= (state_d == ST_RUN);
    end
  end

  assign bus.soc_erst_n    = run_q;
  assign bus.rst_done      = run_q;
  assign bus.dwakeup_n     = ~wake_lvl;
  assign bus.seq_state     = state_q;
  assign bus.lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_e203_rst_sequencer.sv
module tb_e203_rst_sequencer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  e203_rst_sequencer_if #(.LOSS_CNT_W(2)) bus ();

  e203_rst_sequencer #(
    .SYNC_STAGES     (2),
    .LOCK_STABLE_CYC (8),
    .RST_HOLD_CYC    (4),
    .DBNC_CYC        (4),
    .LOSS_CNT_W      (2)
  ) dut (
    .hfextclk  (clk),
    .globalrst (rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst            = 1'b1;
    bus.pll_lock   = 1'b0;
    bus.wakeup_raw = 1'b0;
    bus.sw_rst_req = 1'b0;

    // reset values
    #3;
    chk("rst_erst_n",  8'(bus.soc_erst_n),    8'd0);
    chk("rst_done",    8'(bus.rst_done),      8'd0);
    chk("rst_dwake_n", 8'(bus.dwakeup_n),     8'd1);
    chk("rst_state",   8'(bus.seq_state),     8'd0);
    chk("rst_loss",    8'(bus.lock_loss_cnt), 8'd0);

    edges(2);
    rst = 1'b0;
    edges(3);
    chk("idle_state", 8'(bus.seq_state), 8'd0);

    // lock glitch during STABLE: back to WAIT_LOCK, no loss count
    bus.pll_lock = 1'b1;
    edges(5);
    chk("glitch_in_stable", 8'(bus.seq_state), 8'd1);
    bus.pll_lock = 1'b0;
    edges(3);
    chk("glitch_wait", 8'(bus.seq_state), 8'd0);
    chk("glitch_loss", 8'(bus.lock_loss_cnt), 8'd0);

    // full lock sequence from raw raise at edge 0
    bus.pll_lock = 1'b1;
    edges(2);
    chk("seq_e2_state", 8'(bus.seq_state), 8'd0);
    edges(1);
    chk("seq_e3_state", 8'(bus.seq_state), 8'd1);
    edges(7);
    chk("seq_e10_state", 8'(bus.seq_state), 8'd1);
    edges(1);
    chk("seq_e11_state", 8'(bus.seq_state), 8'd2);
    edges(3);
    chk("seq_e14_state", 8'(bus.seq_state), 8'd2);
    chk("seq_e14_erst",  8'(bus.soc_erst_n), 8'd0);
    edges(1);
    chk("seq_e15_erst",  8'(bus.soc_erst_n), 8'd1);
    chk("seq_e15_done",  8'(bus.rst_done),   8'd1);
    chk("seq_e15_state", 8'(bus.seq_state),  8'd3);
    chk("seq_loss",      8'(bus.lock_loss_cnt), 8'd0);

    // software reset request from RUN
    bus.sw_rst_req = 1'b1;
    edges(1);
    bus.sw_rst_req = 1'b0;
    chk("sw_e1_erst",  8'(bus.soc_erst_n), 8'd0);
    chk("sw_e1_done",  8'(bus.rst_done),   8'd0);
    chk("sw_e1_state", 8'(bus.seq_state),  8'd2);
    edges(3);
    chk("sw_e4_erst", 8'(bus.soc_erst_n), 8'd0);
    edges(1);
    chk("sw_e5_erst",  8'(bus.soc_erst_n), 8'd1);
    chk("sw_e5_state", 8'(bus.seq_state),  8'd3);

    // sw request coincident with synchronised lock loss: LOST wins
    bus.pll_lock = 1'b0;
    edges(2);
    chk("co_e2_state", 8'(bus.seq_state), 8'd3);
    bus.sw_rst_req = 1'b1;
    edges(1);
    bus.sw_rst_req = 1'b0;
    chk("co_e3_state", 8'(bus.seq_state),     8'd4);
    chk("co_e3_erst",  8'(bus.soc_erst_n),    8'd0);
    chk("co_e3_loss",  8'(bus.lock_loss_cnt), 8'd1);
    edges(1);
    chk("co_e4_state", 8'(bus.seq_state), 8'd0);

    // repeated lock loss from RUN; counter saturates at 3
    for (int i = 0; i < 4; i++) begin
      bus.pll_lock = 1'b1;
      edges(14);
      chk("loss_relock_e14", 8'(bus.soc_erst_n), 8'd0);
      edges(1);
      chk("loss_relock_e15", 8'(bus.soc_erst_n), 8'd1);
      bus.pll_lock = 1'b0;
      edges(2);
      chk("loss_e2_erst", 8'(bus.soc_erst_n), 8'd1);
      edges(1);
      chk("loss_e3_erst",  8'(bus.soc_erst_n), 8'd0);
      chk("loss_e3_state", 8'(bus.seq_state),  8'd4);
      chk("loss_cnt", 8'(bus.lock_loss_cnt), (i + 2 > 3) ? 8'd3 : 8'(i + 2));
      edges(1);
      chk("loss_e4_state", 8'(bus.seq_state), 8'd0);
    end

    // 3-cycle wakeup pulse is filtered out
    bus.wakeup_raw = 1'b1;
    edges(3);
    bus.wakeup_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      edges(1);
      chk("wake_short", 8'(bus.dwakeup_n), 8'd1);
    end

    // 6-cycle pulse propagates after 2+4 edges; release debounced too
    bus.wakeup_raw = 1'b1;
    edges(5);
    chk("wake_e5", 8'(bus.dwakeup_n), 8'd1);
    edges(1);
    chk("wake_e6", 8'(bus.dwakeup_n), 8'd0);
    bus.wakeup_raw = 1'b0;
    edges(5);
    chk("wake_e11", 8'(bus.dwakeup_n), 8'd0);
    edges(1);
    chk("wake_e12", 8'(bus.dwakeup_n), 8'd1);

    // async reset while in HOLD
    bus.pll_lock = 1'b1;
    edges(12);
    chk("hold_state", 8'(bus.seq_state), 8'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", 8'(bus.seq_state),     8'd0);
    chk("arst_erst",  8'(bus.soc_erst_n),    8'd0);
    chk("arst_done",  8'(bus.rst_done),      8'd0);
    chk("arst_loss",  8'(bus.lock_loss_cnt), 8'd0);
    chk("arst_dwake", 8'(bus.dwakeup_n),     8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
